cell_stream_scheduler: RTL and testbench
========================================

Name: cell_stream_scheduler

Overview:
Synthesizable, pipelined cell issuer between a cell source (DPI transactor or on-chip line buffer) and the CellProcessor core. It replaces the blocking "send, wait 4 clocks, receive" loop with a valid/ready streaming interface. One cell issues per clock, a fixed-latency valid pipe tracks in-flight results, and a credit-checked result FIFO provides output backpressure. It counts a frame of N pixels and reports completion, so the testbench no longer polls a DPI done flag.

Parameters:
CELL_W, 72, width of one 3x3 cell (9 pixels x 8 b)
PIX_W, 8, processed pixel width
OP_W, 4, opcode width
USER_W, 8, userInput width
CORE_LAT, 4, CellProcessor latency in clocks, issue to processedPixel valid (>=1)
FIFO_DEPTH, 8, result FIFO entries (power of 2, >= CORE_LAT)
CNT_W, 20, frame pixel counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; latches frame_len and opcode/user, begins frame
frame_len  in  CNT_W  pixels in frame (0 = empty frame)
cfg_opcode  in  OP_W  opcode for the frame
cfg_user  in  USER_W  userInputA for the frame
in_valid  in  1  source cell pair valid
in_ready  out  1  scheduler accepts cell pair
in_cellA  in  CELL_W  cell A
in_cellB  in  CELL_W  cell B
core_cellA  out  CELL_W  to CellProcessor cellA
core_cellB  out  CELL_W  to CellProcessor cellB
core_opcode  out  OP_W  to CellProcessor opcode
core_user  out  USER_W  to CellProcessor userInputA
core_pixel  in  PIX_W  CellProcessor processedPixel
out_valid  out  1  result pixel valid
out_ready  in  1  sink accepts result
out_pixel  out  PIX_W  result pixel
out_last  out  1  with final pixel of frame
busy  out  1  state != IDLE/DONE
done  out  1  level, set at frame end, cleared by start

Behaviour:
- Reset: state IDLE; in_ready, out_valid, out_last, busy, done = 0; core_* = 0; counters and FIFO cleared; valid pipe cleared. Reset mid-frame discards all in-flight and buffered results.
- States:
  - IDLE/DONE -> RUN on start (frame_len != 0).
  - start with frame_len == 0 -> DONE directly, with done set next cycle.
  - RUN -> DRAIN when issued count reaches frame_len.
  - DRAIN -> DONE when the pipe is empty, the FIFO is empty, and the last pixel has been popped.
  - start is ignored in RUN/DRAIN.
- Credit: inflight = popcount(valid pipe) + FIFO occupancy. in_ready = (state==RUN) && (issued < frame_len) && (inflight < FIFO_DEPTH).
- Issue: on in_valid && in_ready, register the cells onto core_cellA/B (held otherwise). Shift 1 into valid pipe stage 0; else shift 0. Issued count increments.
- Capture: when valid pipe stage CORE_LAT-1 is set, write core_pixel into the FIFO. Capture is guaranteed non-overflowing by the credit rule.
- Output: FIFO head drives out_pixel/out_valid (show-ahead). Pop on out_valid && out_ready. Output count increments; out_last = out_valid && (popped == frame_len-1).
- Push and pop in the same cycle are both allowed, including when the FIFO is full or empty-with-push bypass disabled (no bypass: one-cycle minimum FIFO latency).
- Throughput: 1 pixel/clk with out_ready held high. Latency from input accept to out_valid = CORE_LAT + 2 clocks.
- Counter wrap is not possible: count saturates at frame_len.

Optional Feature:
CELL_SCHED_STATS_EN.
- Defined: adds outputs stat_in_stall and stat_out_stall (32 b each, cleared on start and reset).
  - stat_in_stall counts RUN cycles with in_valid && !in_ready.
  - stat_out_stall counts cycles with out_valid && !out_ready.
  - Both saturate at all-ones.
- Undefined: ports and logic absent; core behaviour identical.

Decomposition:
- CellSchedPkg holds:
  - sched_state_t enum (IDLE, RUN, DRAIN, DONE)
  - default width constants, which alias CellProcessingPkg cellDepth/pixel widths
- Sub-module cell_result_fifo: parametrised synchronous FIFO (PIX_W, FIFO_DEPTH) with show-ahead head, count output, and simultaneous push/pop.

Test Plan:
- Frame of 16 pixels, in_valid and out_ready held 1, CORE_LAT=4:
  - 16 accepts in 16 consecutive clocks
  - first out_valid 6 clocks after first accept
  - out_last on 16th output
  - done set the next clock
- out_ready=0 for 20 clocks mid-frame:
  - in_ready drops once inflight reaches 8
  - no pixel lost or duplicated; output order matches a model where pixel = f(cellA, cellB)
- start with frame_len=0 -> DONE next cycle, no out_valid, in_ready never 1.
- rst asserted with 5 results in flight:
  - outputs 0 immediately (asynchronous)
  - after release, a new 4-pixel frame produces exactly 4 outputs
- start asserted during RUN is ignored: frame_len/opcode unchanged, count completes at the original length.
- With CELL_SCHED_STATS_EN defined:
  - 3 cycles of in_valid while credits are exhausted -> stat_in_stall = 3
  - 5 cycles of out_ready=0 with out_valid=1 -> stat_out_stall = 5

Source files
------------

// File: rtl/cell_stream_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// cell_stream_scheduler_pkg : scheduler state type and default widths
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cell_stream_scheduler_pkg;

    // Defaults track the CellProcessor cell depth (3x3 x 8 b) and pixel widths
    localparam int CELL_W_DEF     = 72;
    localparam int PIX_W_DEF      = 8;
    localparam int OP_W_DEF       = 4;
    localparam int USER_W_DEF     = 8;
    localparam int CORE_LAT_DEF   = 4;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int CNT_W_DEF      = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/cell_stream_scheduler_if.sv
// ---------------------------------------------------------------------------
// cell_stream_scheduler_if : source, core and sink streams of the scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cell_stream_scheduler_if
    import cell_stream_scheduler_pkg::*;
#(
    parameter int CELL_W = CELL_W_DEF,
    parameter int PIX_W  = PIX_W_DEF,
    parameter int OP_W   = OP_W_DEF,
    parameter int USER_W = USER_W_DEF
) ();

    logic              in_valid;
    logic              in_ready;
    logic [CELL_W-1:0] in_cellA;
    logic [CELL_W-1:0] in_cellB;

    logic [CELL_W-1:0] core_cellA;
    logic [CELL_W-1:0] core_cellB;
    logic [OP_W-1:0]   core_opcode;
    logic [USER_W-1:0] core_user;
    logic [PIX_W-1:0]  core_pixel;

    logic              out_valid;
    logic              out_ready;
    logic [PIX_W-1:0]  out_pixel;
    logic              out_last;

    modport master (
        input  in_valid, in_cellA, in_cellB, core_pixel, out_ready,
        output in_ready, core_cellA, core_cellB, core_opcode, core_user,
               out_valid, out_pixel, out_last
    );

    modport slave (
        output in_valid, in_cellA, in_cellB, core_pixel, out_ready,
        input  in_ready, core_cellA, core_cellB, core_opcode, core_user,
               out_valid, out_pixel, out_last
    );

endinterface

`default_nettype wire

// File: rtl/cell_stream_scheduler_fifo.sv
// ---------------------------------------------------------------------------
// cell_result_fifo : show-ahead synchronous FIFO, simultaneous push/pop
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cell_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    // No bypass: a pushed word becomes visible at the head one clock later
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != FULL_CNT) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_valid = (count_q != '0);
    assign head_data  = mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

`default_nettype wire

// File: rtl/cell_stream_scheduler.sv
// ---------------------------------------------------------------------------
// cell_stream_scheduler : pipelined, credit-checked cell issuer for the
// CellProcessor core. CELL_SCHED_STATS_EN adds stall statistic counters.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cell_stream_scheduler
    import cell_stream_scheduler_pkg::*;
#(
    parameter int CELL_W     = CELL_W_DEF,
    parameter int PIX_W      = PIX_W_DEF,
    parameter int OP_W       = OP_W_DEF,
    parameter int USER_W     = USER_W_DEF,
    parameter int CORE_LAT   = CORE_LAT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       frame_len,
    input  logic [OP_W-1:0]        cfg_opcode,
    input  logic [USER_W-1:0]      cfg_user,
    cell_stream_scheduler_if.master bus,
    output logic                   busy,
    output logic                   done
`ifdef CELL_SCHED_STATS_EN
    ,
    output logic [31:0]            stat_in_stall,
    output logic [31:0]            stat_out_stall
`endif
);

    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int IF_W = $clog2(CORE_LAT + FIFO_DEPTH + 2);

    sched_state_t      state_q, state_d;
    logic [CNT_W-1:0]  frame_len_q;
    logic [CNT_W-1:0]  issued_q;
    logic [CNT_W-1:0]  popped_q;
    logic [OP_W-1:0]   opcode_q;
    logic [USER_W-1:0] user_q;
    logic [CELL_W-1:0] cellA_q;
    logic [CELL_W-1:0] cellB_q;
    logic [CORE_LAT-1:0] vpipe_q;
    logic              cap_valid_q;
    logic [PIX_W-1:0]  cap_pixel_q;

    logic [CW-1:0]     fifo_count;
    logic              fifo_valid;
    logic [PIX_W-1:0]  fifo_data;
    logic [IF_W-1:0]   inflight;
    logic              start_acc;
    logic              in_ready;
    logic              issue;
    logic              pop;
    logic              last_pix;
    logic              drain_done;

    assign start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Everything issued but not yet popped: core pipe, capture stage, FIFO
    always_comb begin
        inflight = IF_W'(cap_valid_q) + IF_W'(fifo_count);
        for (int i = 0; i < CORE_LAT; i++) begin
            inflight = inflight + IF_W'(vpipe_q[i]);
        end
    end

    assign in_ready   = (state_q == ST_RUN) && (issued_q < frame_len_q) &&
                        (inflight < IF_W'(FIFO_DEPTH));
    assign issue      = bus.in_valid && in_ready;
    assign pop        = fifo_valid && bus.out_ready;
    assign last_pix   = fifo_valid && (popped_q == frame_len_q - CNT_W'(1));
    assign drain_done = pop && last_pix && (vpipe_q == '0) && !cap_valid_q &&
                        (fifo_count == CW'(1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = (frame_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issued_q == frame_len_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            frame_len_q <= '0;
            opcode_q    <= '0;
            user_q      <= '0;
            issued_q    <= '0;
            popped_q    <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                frame_len_q <= frame_len;
                opcode_q    <= cfg_opcode;
                user_q      <= cfg_user;
                issued_q    <= '0;
                popped_q    <= '0;
            end else begin
                if (issue) begin
                    issued_q <= issued_q + CNT_W'(1);
                end
                if (pop) begin
                    popped_q <= popped_q + CNT_W'(1);
                end
            end
        end
    end

    // The core is fed from registers; the valid pipe mirrors its latency and
    // one extra capture stage registers core_pixel before the FIFO write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cellA_q     <= '0;
            cellB_q     <= '0;
            vpipe_q     <= '0;
            cap_valid_q <= 1'b0;
            cap_pixel_q <= '0;
        end else begin
            if (issue) begin
                cellA_q <= bus.in_cellA;
                cellB_q <= bus.in_cellB;
            end
            vpipe_q[0] <= issue;
            for (int i = 1; i < CORE_LAT; i++) begin
                vpipe_q[i] <= vpipe_q[i-1];
            end
            cap_valid_q <= vpipe_q[CORE_LAT-1];
            if (vpipe_q[CORE_LAT-1]) begin
                cap_pixel_q <= bus.core_pixel;
            end
        end
    end

    cell_result_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (cap_valid_q),
        .push_data  (cap_pixel_q),
        .pop        (pop),
        .head_valid (fifo_valid),
        .head_data  (fifo_data),
        .count      (fifo_count)
    );

    assign bus.in_ready    = in_ready;
    assign bus.core_cellA  = cellA_q;
    assign bus.core_cellB  = cellB_q;
    assign bus.core_opcode = opcode_q;
    assign bus.core_user   = user_q;
    assign bus.out_valid   = fifo_valid;
    assign bus.out_pixel   = fifo_data;
    assign bus.out_last    = last_pix;

    assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done = (state_q == ST_DONE);

`ifdef CELL_SCHED_STATS_EN
    logic [31:0] stat_in_q;
    logic [31:0] stat_out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_in_q  <= '0;
            stat_out_q <= '0;
        end else if (start_acc) begin
            stat_in_q  <= '0;
            stat_out_q <= '0;
        end else begin
            if ((state_q == ST_RUN) && bus.in_valid && !in_ready && (stat_in_q != '1)) begin
                stat_in_q <= stat_in_q + 32'd1;
            end
            if (fifo_valid && !bus.out_ready && (stat_out_q != '1)) begin
                stat_out_q <= stat_out_q + 32'd1;
            end
        end
    end

    assign stat_in_stall  = stat_in_q;
    assign stat_out_stall = stat_out_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cell_stream_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cell_stream_scheduler : randomized bench with a queue-based reference
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cell_stream_scheduler;
    import cell_stream_scheduler_pkg::*;

    localparam int CELL_W     = 72;
    localparam int PIX_W      = 8;
    localparam int OP_W       = 4;
    localparam int USER_W     = 8;
    localparam int CORE_LAT   = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  frame_len;
    logic [OP_W-1:0]   cfg_opcode;
    logic [USER_W-1:0] cfg_user;
    logic              busy;
    logic              done;

    cell_stream_scheduler_if #(
        .CELL_W (CELL_W), .PIX_W (PIX_W), .OP_W (OP_W), .USER_W (USER_W)
    ) bus ();

`ifdef CELL_SCHED_STATS_EN
    logic [31:0] stat_in_stall;
    logic [31:0] stat_out_stall;
`endif

    cell_stream_scheduler #(
        .CELL_W (CELL_W), .PIX_W (PIX_W), .OP_W (OP_W), .USER_W (USER_W),
        .CORE_LAT (CORE_LAT), .FIFO_DEPTH (FIFO_DEPTH), .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .frame_len  (frame_len),
        .cfg_opcode (cfg_opcode),
        .cfg_user   (cfg_user),
        .bus        (bus),
        .busy       (busy),
        .done       (done)
`ifdef CELL_SCHED_STATS_EN
        ,
        .stat_in_stall  (stat_in_stall),
        .stat_out_stall (stat_out_stall)
`endif
    );

    always #5 clk = ~clk;

    // Pixel function of the CellProcessor stand-in
    function automatic logic [7:0] pix_fn(input logic [71:0] a, input logic [71:0] b,
                                          input logic [3:0] op, input logic [7:0] u);
        logic [7:0] s;
        s = 8'd0;
        for (int i = 0; i < 9; i++) s = s + a[i*8 +: 8] - b[i*8 +: 8];
        return s ^ u ^ {op, op};
    endfunction

    // CellProcessor stand-in: result valid CORE_LAT clocks after issue
    logic [PIX_W-1:0] core_pipe [CORE_LAT-1];
    always @(posedge clk) begin
        core_pipe[0] <= pix_fn(bus.core_cellA, bus.core_cellB, bus.core_opcode, bus.core_user);
        for (int i = 1; i < CORE_LAT-1; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign bus.core_pixel = core_pipe[CORE_LAT-2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: each accepted pair yields one pixel, delivered in accept order
    logic [7:0]  exp_q [$];
    int          exp_len, acc_cnt, out_cnt, stall_cnt;
    int          first_acc, last_acc, first_out, last_out_cyc;
    logic [3:0]  m_op;
    logic [7:0]  m_user;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(pix_fn(bus.in_cellA, bus.in_cellB, m_op, m_user));
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                acc_cnt++;
            end
            if (bus.out_valid && first_out < 0) first_out = cyc;
            if (bus.out_valid && !bus.out_ready) stall_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                check_eq("model_has_pixel", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check_eq("out_pixel", 32'(bus.out_pixel), 32'(exp_q.pop_front()));
                out_cnt++;
                check_eq("out_last", 32'(bus.out_last), 32'(out_cnt == exp_len));
                if (bus.out_last) last_out_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int len, input logic [3:0] op, input logic [7:0] u);
        frame_len  = CNT_W'(len);
        cfg_opcode = op;
        cfg_user   = u;
        start      = 1'b1;
        m_op = op; m_user = u; exp_len = len;
        acc_cnt = 0; out_cnt = 0; stall_cnt = 0;
        first_acc = -1; last_acc = -1; first_out = -1; last_out_cyc = -1;
        exp_q.delete();
        tick();
        start = 1'b0;
    endtask

    task automatic drive_cycle(input int pv, input int pr);
        logic [95:0] ra, rb;
        ra = {$urandom(), $urandom(), $urandom()};
        rb = {$urandom(), $urandom(), $urandom()};
        bus.in_valid  = ($urandom_range(99) < pv);
        bus.in_cellA  = ra[71:0];
        bus.in_cellB  = rb[71:0];
        bus.out_ready = ($urandom_range(99) < pr);
        tick();
    endtask

    task automatic run_until_done(input int pv, input int pr, input int budget,
                                  input string tag, output int done_cyc);
        int n;
        n = 0;
        while (!done && n < budget) begin
            drive_cycle(pv, pr);
            n++;
        end
        done_cyc = cyc;
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_outputs"}, 32'(out_cnt), 32'(exp_len));
        check_eq({tag, "_accepts"}, 32'(acc_cnt), 32'(exp_len));
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int dc;
        rst = 1'b1; start = 1'b0; frame_len = '0; cfg_opcode = '0; cfg_user = '0;
        bus.in_valid = 1'b0; bus.in_cellA = '0; bus.in_cellB = '0; bus.out_ready = 1'b0;
        m_op = '0; m_user = '0; exp_len = 0; acc_cnt = 0; out_cnt = 0; stall_cnt = 0;
        first_acc = -1; last_acc = -1; first_out = -1; last_out_cyc = -1;
        #23;
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_core_cellA", 32'(bus.core_cellA), 32'd0);
        tick(); rst = 1'b0; tick();

        // 16-pixel frame at full rate
        start_frame(16, 4'h5, 8'hA3);
        run_until_done(100, 100, 200, "f16", dc);
        check_eq("f16_accept_span", 32'(last_acc - first_acc), 32'd15);
        check_eq("f16_latency", 32'(first_out - first_acc), 32'(CORE_LAT + 2));
        check_eq("f16_done_after_last", 32'(dc - last_out_cyc), 32'd1);

        // Output stalled for 20 clocks mid-frame
        start_frame(40, 4'h9, 8'h3C);
        repeat (6) drive_cycle(100, 100);
        repeat (20) drive_cycle(100, 0);
        check_eq("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("stall_inflight", 32'(acc_cnt - out_cnt), 32'(FIFO_DEPTH));
        run_until_done(100, 100, 400, "stall", dc);
`ifdef CELL_SCHED_STATS_EN
        check_eq("stat_out_stall", stat_out_stall, 32'(stall_cnt));
`endif

        // Empty frame
        start_frame(0, 4'h1, 8'h01);
        check_eq("empty_done", 32'(done), 32'd1);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            #1;
            check_eq("empty_in_ready", 32'(bus.in_ready), 32'd0);
            check_eq("empty_out_valid", 32'(bus.out_valid), 32'd0);
            tick();
        end
        bus.in_valid = 1'b0;

        // Reset with results in flight
        start_frame(10, 4'h2, 8'h77);
        repeat (5) drive_cycle(100, 0);
        bus.in_valid = 1'b0;
        check_eq("pre_rst_accepts", 32'(acc_cnt), 32'd5);
        #2 rst = 1'b1;
        #1;
        check_eq("async_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("async_busy", 32'(busy), 32'd0);
        check_eq("async_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("async_core_opcode", 32'(bus.core_opcode), 32'd0);
        tick(); tick(); rst = 1'b0; tick();
        start_frame(4, 4'h6, 8'h42);
        run_until_done(100, 100, 100, "post_rst", dc);

        // Start during RUN must be ignored
        start_frame(12, 4'h3, 8'h5A);
        repeat (3) drive_cycle(100, 100);
        start = 1'b1; frame_len = CNT_W'(3); cfg_opcode = 4'hC; cfg_user = 8'h11;
        drive_cycle(100, 100);
        start = 1'b0;
        check_eq("ignored_start_opcode", 32'(bus.core_opcode), 32'h3);
        check_eq("ignored_start_busy", 32'(busy), 32'd1);
        run_until_done(100, 100, 200, "ignored_start", dc);

        // Random frames with random handshakes
        for (int f = 0; f < 5; f++) begin
            start_frame($urandom_range(1, 40), 4'($urandom()), 8'($urandom()));
            run_until_done($urandom_range(30, 100), $urandom_range(30, 100), 3000, "rand", dc);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
